// File: rtl/shared_data_memory.sv
// Shared word RAM serving NCORES cores through a round-robin arbiter; a grant takes one ARB cycle,
// completion (ready[i], read data in din slot i) is signalled in the following RESP cycle; cores stall until ready.
module shared_data_memory #(
   parameter int NCORES = 2,
   parameter int DEPTH  = 256,
   parameter int AW     = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NCORES-1:0]    memread,
   input  logic [NCORES-1:0]    memwr,
   input  logic [16*NCORES-1:0] dmaddr,
   input  logic [16*NCORES-1:0] dout,
   output logic [16*NCORES-1:0] din,
   output logic [NCORES-1:0]    ready
);

   localparam int PW = (NCORES > 1) ? $clog2(NCORES) : 1;

   typedef enum logic {ARB, RESP} state_t;

   state_t            state;
   logic [PW-1:0]     rr_ptr;
   logic [PW-1:0]     gnt;
   logic [PW-1:0]     cand;
   logic [PW-1:0]     rr_nxt;
   logic [NCORES-1:0] req;
   logic              req_any;
   logic [AW-1:0]     gnt_addr;
   logic [15:0]       gnt_wdat;
   logic              gnt_wr;
   logic [15:0]       mem [DEPTH];

   // Scan from the highest offset down so the requester closest to rr_ptr wins.
   always_comb begin
      int idx;
      idx     = 0;
      cand    = '0;
      req     = memread | memwr;
      req_any = |req;
      gnt     = rr_ptr;
      for (int k = NCORES - 1; k >= 0; k--) begin
         idx = int'(rr_ptr) + k;
         if (idx >= NCORES) idx = idx - NCORES;
         cand = PW'(idx);
         if (req[cand]) gnt = cand;
      end
      gnt_addr = dmaddr[16*gnt +: AW];
      gnt_wdat = dout[16*gnt +: 16];
      gnt_wr   = memwr[gnt];
      rr_nxt   = (int'(gnt) == NCORES - 1) ? '0 : gnt + PW'(1);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= ARB;
         rr_ptr <= '0;
         ready  <= '0;
         din    <= '0;
      end else begin
         case (state)
            ARB: begin
               ready <= '0;
               if (req_any) begin
                  if (!gnt_wr) din[16*gnt +: 16] <= mem[gnt_addr];
                  ready[gnt] <= 1'b1;
                  rr_ptr     <= rr_nxt;
                  state      <= RESP;
               end
            end
            RESP: begin
               ready <= '0;
               state <= ARB;
            end
         endcase
      end
   end

   // RAM is never cleared; a write wins over a read when both strobes are set.
   always_ff @(posedge clk) begin
      if (!rst && state == ARB && req_any && gnt_wr) mem[gnt_addr] <= gnt_wdat;
   end

endmodule

// File: tb/tb_shared_data_memory.sv
// Directed bench for shared_data_memory with two cores; inputs driven and outputs sampled on the falling edge.
module tb_shared_data_memory;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [1:0]  memread = '0;
   logic [1:0]  memwr = '0;
   logic [31:0] dmaddr = '0;
   logic [31:0] dout = '0;
   logic [31:0] din;
   logic [1:0]  ready;

   int compared = 0;
   int mismatched = 0;

   shared_data_memory #(.NCORES(2), .DEPTH(256), .AW(8)) dut (
      .clk(clk), .rst(rst), .memread(memread), .memwr(memwr),
      .dmaddr(dmaddr), .dout(dout), .din(din), .ready(ready)
   );

   always #5 clk = ~clk;

   // Issue one access from a falling edge and wait (bounded) for that core's ready pulse.
   task automatic access(input int core, input logic rd, input logic wr,
                         input logic [15:0] addr, input logic [15:0] data,
                         output int cycles, output logic got);
      memread[core] = rd;
      memwr[core]   = wr;
      dmaddr[16*core +: 16] = addr;
      dout[16*core +: 16]   = data;
      got = 1'b0;
      cycles = 0;
      for (int i = 1; i <= 10 && !got; i++) begin
         @(negedge clk);
         if (ready[core]) begin
            got = 1'b1;
            cycles = i;
         end
      end
      memread[core] = 1'b0;
      memwr[core]   = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      compared++;
      if (ready !== 2'b00) begin
         mismatched++;
         $display("FAIL reset_ready: got %b expected 00", ready);
      end
      compared++;
      if (din !== 32'h0) begin
         mismatched++;
         $display("FAIL reset_din: got %h expected 00000000", din);
      end
      rst = 1'b0;
   endtask

   task automatic test_write_read();
      int c;
      logic g;
      access(0, 1'b0, 1'b1, 16'h0005, 16'hBEEF, c, g);
      compared++;
      if (g !== 1'b1 || c != 1) begin
         mismatched++;
         $display("FAIL wr_latency: got ready=%b after %0d cycles expected ready after 1", g, c);
      end
      compared++;
      if (ready !== 2'b01) begin
         mismatched++;
         $display("FAIL wr_ready_bits: got %b expected 01", ready);
      end
      access(0, 1'b1, 1'b0, 16'h0005, 16'h0000, c, g);
      compared++;
      if (g !== 1'b1 || c != 2) begin
         mismatched++;
         $display("FAIL rd_latency: got ready=%b after %0d cycles expected ready after 2", g, c);
      end
      compared++;
      if (din[15:0] !== 16'hBEEF) begin
         mismatched++;
         $display("FAIL rd_data: got %h expected beef", din[15:0]);
      end
      @(negedge clk);
      compared++;
      if (ready !== 2'b00) begin
         mismatched++;
         $display("FAIL rd_pulse_width: got %b expected 00", ready);
      end
   endtask

   task automatic test_round_robin();
      int c;
      logic g;
      logic [1:0] exp_rdy [8];
      exp_rdy = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01, 2'b00, 2'b10, 2'b00};
      access(0, 1'b0, 1'b1, 16'h0040, 16'h1111, c, g);
      access(1, 1'b0, 1'b1, 16'h0041, 16'h2222, c, g);
      memread = 2'b11;
      dmaddr  = {16'h0041, 16'h0040};
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         compared++;
         if (ready !== exp_rdy[i]) begin
            mismatched++;
            $display("FAIL rr_ready[%0d]: got %b expected %b", i, ready, exp_rdy[i]);
         end
         if (i == 0) begin
            compared++;
            if (din[15:0] !== 16'h1111) begin
               mismatched++;
               $display("FAIL rr_din0: got %h expected 1111", din[15:0]);
            end
         end
         if (i == 2) begin
            compared++;
            if (din[31:16] !== 16'h2222) begin
               mismatched++;
               $display("FAIL rr_din1: got %h expected 2222", din[31:16]);
            end
         end
      end
      memread = 2'b00;
   endtask

   task automatic test_contention();
      int c;
      logic g;
      // Core0 access moves rr_ptr to 1.
      access(0, 1'b1, 1'b0, 16'h0005, 16'h0000, c, g);
      memread[0] = 1'b1;
      dmaddr[15:0] = 16'h0010;
      memwr[1] = 1'b1;
      dmaddr[31:16] = 16'h0010;
      dout[31:16] = 16'h1234;
      @(negedge clk);
      compared++;
      if (ready !== 2'b00) begin
         mismatched++;
         $display("FAIL cont_arb0: got %b expected 00", ready);
      end
      @(negedge clk);
      compared++;
      if (ready !== 2'b10) begin
         mismatched++;
         $display("FAIL cont_first_grant: got %b expected 10", ready);
      end
      memwr[1] = 1'b0;
      @(negedge clk);
      compared++;
      if (ready !== 2'b00) begin
         mismatched++;
         $display("FAIL cont_arb1: got %b expected 00", ready);
      end
      @(negedge clk);
      compared++;
      if (ready !== 2'b01) begin
         mismatched++;
         $display("FAIL cont_second_grant: got %b expected 01", ready);
      end
      compared++;
      if (din[15:0] !== 16'h1234) begin
         mismatched++;
         $display("FAIL cont_read_data: got %h expected 1234", din[15:0]);
      end
      memread[0] = 1'b0;
   endtask

   task automatic test_alias();
      int c;
      logic g;
      access(1, 1'b0, 1'b1, 16'h0103, 16'hAAAA, c, g);
      access(0, 1'b1, 1'b0, 16'h0003, 16'h0000, c, g);
      compared++;
      if (g !== 1'b1 || din[15:0] !== 16'hAAAA) begin
         mismatched++;
         $display("FAIL alias_read: got ready=%b din0=%h expected ready=1 din0=aaaa", g, din[15:0]);
      end
   endtask

   task automatic test_rd_wr_both();
      int c;
      logic g;
      access(0, 1'b1, 1'b1, 16'h0020, 16'h5555, c, g);
      compared++;
      if (g !== 1'b1 || ready !== 2'b01) begin
         mismatched++;
         $display("FAIL both_ready: got seen=%b ready=%b expected seen=1 ready=01", g, ready);
      end
      compared++;
      if (din[15:0] !== 16'hAAAA) begin
         mismatched++;
         $display("FAIL both_din_kept: got %h expected aaaa", din[15:0]);
      end
      @(negedge clk);
      compared++;
      if (ready !== 2'b00) begin
         mismatched++;
         $display("FAIL both_single_pulse: got %b expected 00", ready);
      end
      access(1, 1'b1, 1'b0, 16'h0020, 16'h0000, c, g);
      compared++;
      if (din[31:16] !== 16'h5555) begin
         mismatched++;
         $display("FAIL both_ram_written: got %h expected 5555", din[31:16]);
      end
      compared++;
      if (din[15:0] !== 16'hAAAA) begin
         mismatched++;
         $display("FAIL both_din0_untouched: got %h expected aaaa", din[15:0]);
      end
   endtask

   task automatic test_reset_in_resp();
      int c;
      logic g;
      @(negedge clk);
      memwr[1] = 1'b1;
      dmaddr[31:16] = 16'h0030;
      dout[31:16] = 16'h7777;
      @(negedge clk);
      compared++;
      if (ready !== 2'b10) begin
         mismatched++;
         $display("FAIL rstresp_ready_before: got %b expected 10", ready);
      end
      rst = 1'b1;
      memwr[1] = 1'b0;
      @(negedge clk);
      compared++;
      if (ready !== 2'b00) begin
         mismatched++;
         $display("FAIL rstresp_ready_after: got %b expected 00", ready);
      end
      compared++;
      if (din !== 32'h0) begin
         mismatched++;
         $display("FAIL rstresp_din_after: got %h expected 00000000", din);
      end
      rst = 1'b0;
      access(0, 1'b1, 1'b0, 16'h0030, 16'h0000, c, g);
      compared++;
      if (g !== 1'b1 || din[15:0] !== 16'h7777) begin
         mismatched++;
         $display("FAIL rstresp_write_kept: got ready=%b din0=%h expected ready=1 din0=7777", g, din[15:0]);
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_write_read();
      test_round_robin();
      test_contention();
      test_alias();
      test_rd_wr_both();
      test_reset_in_resp();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
